// File: rtl/seq_divider6.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Three-state control (IDLE/RUN/DONE) with registered status and results.
module seq_divider6 #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    stepCount;
  logic [WIDTH-1:0] dvdShift;
  logic [WIDTH-1:0] dvsHold;
  logic [WIDTH-1:0] partial;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             noBorrow;
  logic [WIDTH-1:0] partialNext;
  logic [WIDTH-1:0] dvdNext;
  logic             lastStep;
  logic             accept;

  // One restoring step: shift in the next dividend bit, try to subtract.
  // The low WIDTH bits of the difference are exact whenever it is kept,
  // including divisor 0 where the partial remainder simply collects the
  // dividend and every quotient bit comes out 1.
  always_comb begin
    shifted     = {partial, dvdShift[WIDTH-1]};
    noBorrow    = (shifted >= {1'b0, dvsHold});
    trial       = shifted[WIDTH-1:0] - dvsHold;
    partialNext = noBorrow ? trial : shifted[WIDTH-1:0];
    dvdNext     = WIDTH'({dvdShift, noBorrow});
    lastStep    = (stepCount == LastCount);
    accept      = start && (state != RUN);
  end

  // Control FSM plus datapath registers; results move only on the last step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      stepCount   <= '0;
      dvdShift    <= '0;
      dvsHold     <= '0;
      partial     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            state     <= RUN;
            stepCount <= '0;
            dvdShift  <= dividend;
            dvsHold   <= divisor;
            partial   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        RUN: begin
          dvdShift <= dvdNext;
          partial  <= partialNext;
          if (lastStep) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= dvdNext;
            remainder   <= partialNext;
            div_by_zero <= (dvsHold == '0);
          end else begin
            stepCount <= stepCount + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
